// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/branch control stage in front of the ALU register file.
// Optional single-step gating is compiled in with `define ALU_SEQ_STEP_EN (adds step input, WAITSTEP state).
module alu_sequencer #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST,
`ifdef ALU_SEQ_STEP_EN
    input  logic              step,
`endif
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    input  logic [5:0]        status,
    output logic [2:0]        operandIndex1,
    output logic [2:0]        operandIndex2,
    output logic [2:0]        resultsIndex,
    output logic [6:0]        operation,
    output logic [3:0]        params,
    output logic              readBus,
    output logic [15:0]       imm,
    output logic              halted,
    output logic              illegal
);

`ifdef ALU_SEQ_STEP_EN
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_IMM, S_EXEC, S_HALT, S_WAITSTEP} state_t;
    localparam state_t S_IDLE = S_WAITSTEP;
`else
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_IMM, S_EXEC, S_HALT} state_t;
    localparam state_t S_IDLE = S_FETCH;
`endif

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_ADDSUB = 4'd1,
        OP_MUL    = 4'd2,
        OP_LOG    = 4'd3,
        OP_LSH    = 4'd4,
        OP_RSH    = 4'd5,
        OP_CMP    = 4'd6,
        OP_LDI    = 4'd7,
        OP_JMP    = 4'd8,
        OP_BR     = 4'd9,
        OP_HALT   = 4'd15
    } opcode_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [15:0]       ir, ir_n;
    logic [15:0]       imm_q, imm_n;

    logic [3:0]        opc;
    logic [1:0]        sub;
    logic              ibit;
    logic              flag;
    logic [ADDR_W-1:0] target;
    logic              status_unused;

    assign opc           = ir[15:12];
    assign sub           = ir[1:0];
    assign ibit          = ir[2];
    assign target        = ADDR_W'(imm_q);
    assign status_unused = ^status[2:1];

    always_comb begin
        case (sub)
            2'd0:    flag = status[0];
            2'd1:    flag = status[3];
            2'd2:    flag = status[4];
            default: flag = status[5];
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
            imm_q <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            imm_q <= imm_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        ir_n          = ir;
        imm_n         = imm_q;
        mem_req       = 1'b0;
        mem_addr      = pc;
        operation     = '0;
        params        = '0;
        readBus       = 1'b0;
        illegal       = 1'b0;
        imm           = imm_q;
        halted        = 1'b0;
        operandIndex1 = ir[8:6];
        operandIndex2 = ir[5:3];
        resultsIndex  = ir[11:9];

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_n    = mem_rdata;
                    pc_n    = pc + ADDR_W'(1);
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                illegal = (opc >= 4'd10) && (opc <= 4'd14);
                if (opc == OP_HALT)
                    state_n = S_HALT;
                else if (ibit || opc == OP_LDI || opc == OP_JMP || opc == OP_BR)
                    state_n = S_IMM;
                else
                    state_n = S_EXEC;
            end
            S_IMM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    imm_n   = mem_rdata;
                    pc_n    = pc + ADDR_W'(1);
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opc)
                    OP_ADDSUB: operation = 7'b100_0001;
                    OP_MUL:    operation = 7'b100_0010;
                    OP_LOG:    operation = 7'b100_0100;
                    OP_LSH:    operation = 7'b100_1000;
                    OP_RSH:    operation = 7'b101_0000;
                    OP_CMP:    operation = 7'b110_0000;
                    OP_LDI:    operation = 7'b100_0000;
                    default:   operation = '0;
                endcase
                if (opc >= OP_ADDSUB && opc <= OP_CMP) begin
                    params  = {2'b00, sub};
                    readBus = ibit;
                end else if (opc == OP_LDI) begin
                    readBus = 1'b1;
                end
                if (opc == OP_JMP || (opc == OP_BR && flag))
                    pc_n = target;
                state_n = S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
`ifdef ALU_SEQ_STEP_EN
            S_WAITSTEP: begin
                if (step)
                    state_n = S_FETCH;
            end
`endif
            default: state_n = S_IDLE;
        endcase

        // Reset cycle must present an all-quiet interface regardless of stale state.
        if (RST) begin
            mem_req       = 1'b0;
            mem_addr      = '0;
            operation     = '0;
            params        = '0;
            readBus       = 1'b0;
            illegal       = 1'b0;
            imm           = '0;
            halted        = 1'b0;
            operandIndex1 = '0;
            operandIndex2 = '0;
            resultsIndex  = '0;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: expected fetch addresses and EXEC control words are queued
// when a program is loaded and compared against what the DUT issues.
module tb_alu_sequencer;

    typedef struct packed {
        logic [6:0]  op;
        logic        rb;
        logic [3:0]  par;
        logic [15:0] imm;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
    } exec_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [5:0]  status = '0;
    logic        mem_req, mem_ack, readBus, halted, illegal;
    logic [15:0] mem_addr, mem_rdata, imm;
    logic [2:0]  operandIndex1, operandIndex2, resultsIndex;
    logic [6:0]  operation;
    logic [3:0]  params;

    logic        w_req, w_ack, w_rb, w_halted, w_ill;
    logic [15:0] w_addr, w_rdata, w_imm;
    logic [2:0]  w_oi1, w_oi2, w_ri;
    logic [6:0]  w_op;
    logic [3:0]  w_par;

    logic [15:0] mem [0:65535];
    int unsigned ack_delay = 0;
    logic        ack_force = 1'b0;
    int unsigned wait_cnt = 0;
    int unsigned cyc = 0;

    int          checks = 0;
    int          failures = 0;

    logic [15:0] exp_fetch[$];
    exec_t       exp_exec[$];
    logic [15:0] obs_fetch[$];
    int unsigned obs_fcyc[$];
    exec_t       obs_exec[$];
    logic [15:0] obs_w[$];
    int unsigned ill_cnt = 0;

    always #5 CLK = ~CLK;

    assign mem_ack   = (mem_req && wait_cnt >= ack_delay) || ack_force;
    assign mem_rdata = mem[mem_addr];
    assign w_ack     = w_req;
    assign w_rdata   = mem[w_addr];

    alu_sequencer dut (
        .CLK(CLK), .RST(RST),
`ifdef ALU_SEQ_STEP_EN
        .step(1'b1),
`endif
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .status(status), .operandIndex1(operandIndex1), .operandIndex2(operandIndex2),
        .resultsIndex(resultsIndex), .operation(operation), .params(params),
        .readBus(readBus), .imm(imm), .halted(halted), .illegal(illegal)
    );

    alu_sequencer #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_w (
        .CLK(CLK), .RST(RST),
`ifdef ALU_SEQ_STEP_EN
        .step(1'b1),
`endif
        .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_ack), .mem_rdata(w_rdata),
        .status(status), .operandIndex1(w_oi1), .operandIndex2(w_oi2),
        .resultsIndex(w_ri), .operation(w_op), .params(w_par),
        .readBus(w_rb), .imm(w_imm), .halted(w_halted), .illegal(w_ill)
    );

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    always @(negedge CLK) begin
        if (RST) begin
            obs_fetch.delete(); obs_fcyc.delete(); obs_exec.delete(); obs_w.delete();
            ill_cnt = 0;
        end else begin
            if (mem_req && mem_ack) begin
                obs_fetch.push_back(mem_addr);
                obs_fcyc.push_back(cyc);
            end
            if (operation[6])
                obs_exec.push_back({operation, readBus, params, imm, resultsIndex, operandIndex1, operandIndex2});
            if (illegal) ill_cnt++;
            if (w_req && w_ack) obs_w.push_back(w_addr);
        end
    end

    task automatic new_prog();
        exp_fetch.delete();
        exp_exec.delete();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
    endtask

    task automatic wait_halt(input bit use_w, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLK);
            if ((use_w ? w_halted : halted) === 1'b1) ok = 1'b1;
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        new_prog();
        mem[0] = 16'h1022; mem[1] = 16'hF000;
        @(posedge CLK); #1 RST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({mem_req, mem_addr, operation, params, readBus, imm, halted, illegal,
             resultsIndex, operandIndex1, operandIndex2} !== '0) begin
            failures++;
            $display("FAIL reset_outputs req=%b addr=%h op=%h imm=%h halted=%b required all 0",
                     mem_req, mem_addr, operation, imm, halted);
        end
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL reset_first_req req=%b addr=%h required 1/0000", mem_req, mem_addr);
        end
    endtask

    task automatic test_basic();
        bit ok;
        new_prog();
        mem[0] = 16'h1022; mem[1] = 16'hF000;
        exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001);
        exp_exec.push_back('{op:7'h41, rb:1'b0, par:4'h2, imm:16'h0000, rd:3'd0, rs1:3'd0, rs2:3'd4});
        do_reset();
        wait_halt(1'b0, 200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_halt halted=%b required 1", halted); end
        checks++;
        if (obs_fetch.size() != exp_fetch.size() || obs_exec.size() != exp_exec.size()) begin
            failures++;
            $display("FAIL basic_counts fetches=%0d execs=%0d required %0d/%0d",
                     obs_fetch.size(), obs_exec.size(), exp_fetch.size(), exp_exec.size());
        end
        foreach (exp_fetch[i]) begin
            checks++;
            if (i >= obs_fetch.size() || obs_fetch[i] !== exp_fetch[i]) begin
                failures++;
                $display("FAIL basic_fetch%0d got=%h required=%h", i,
                         (i < obs_fetch.size()) ? obs_fetch[i] : 16'hxxxx, exp_fetch[i]);
            end
        end
        foreach (exp_exec[i]) begin
            checks++;
            if (i >= obs_exec.size() || obs_exec[i] !== exp_exec[i]) begin
                failures++;
                $display("FAIL basic_exec%0d got=%h required=%h", i,
                         (i < obs_exec.size()) ? obs_exec[i] : '0, exp_exec[i]);
            end
        end
        checks++;
        if (obs_fcyc.size() < 2 || obs_fcyc[1] - obs_fcyc[0] != 3) begin
            failures++;
            $display("FAIL basic_latency got=%0d required=3",
                     (obs_fcyc.size() < 2) ? 0 : obs_fcyc[1] - obs_fcyc[0]);
        end
    endtask

    task automatic test_ldi();
        bit ok;
        new_prog();
        mem[0] = 16'h7400; mem[1] = 16'h1234; mem[2] = 16'hF000;
        exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001); exp_fetch.push_back(16'h0002);
        exp_exec.push_back('{op:7'h40, rb:1'b1, par:4'h0, imm:16'h1234, rd:3'd2, rs1:3'd0, rs2:3'd0});
        do_reset();
        wait_halt(1'b0, 200, ok);
        checks++;
        if (!ok || obs_fetch.size() != exp_fetch.size() || obs_exec.size() != exp_exec.size()) begin
            failures++;
            $display("FAIL ldi_counts halted=%b fetches=%0d execs=%0d required 1/%0d/%0d",
                     halted, obs_fetch.size(), obs_exec.size(), exp_fetch.size(), exp_exec.size());
        end
        foreach (exp_fetch[i]) begin
            checks++;
            if (i >= obs_fetch.size() || obs_fetch[i] !== exp_fetch[i]) begin
                failures++;
                $display("FAIL ldi_fetch%0d got=%h required=%h", i,
                         (i < obs_fetch.size()) ? obs_fetch[i] : 16'hxxxx, exp_fetch[i]);
            end
        end
        foreach (exp_exec[i]) begin
            checks++;
            if (i >= obs_exec.size() || obs_exec[i] !== exp_exec[i]) begin
                failures++;
                $display("FAIL ldi_exec%0d got=%h required=%h", i,
                         (i < obs_exec.size()) ? obs_exec[i] : '0, exp_exec[i]);
            end
        end
        checks++;
        if (obs_fcyc.size() < 3 || obs_fcyc[2] - obs_fcyc[0] != 4) begin
            failures++;
            $display("FAIL ldi_latency got=%0d required=4",
                     (obs_fcyc.size() < 3) ? 0 : obs_fcyc[2] - obs_fcyc[0]);
        end
    endtask

    task automatic test_branch(input bit taken);
        bit ok;
        new_prog();
        // CMP rd=5 rs1=1 rs2=2; BR eq -> 0x0040
        mem[0] = 16'h6A50; mem[1] = 16'h9001; mem[2] = 16'h0040; mem[3] = 16'hF000;
        mem[16'h0040] = 16'hF000;
        status = taken ? 6'b001000 : 6'b110111;
        exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001); exp_fetch.push_back(16'h0002);
        exp_fetch.push_back(taken ? 16'h0040 : 16'h0003);
        exp_exec.push_back('{op:7'h60, rb:1'b0, par:4'h0, imm:16'h0000, rd:3'd5, rs1:3'd1, rs2:3'd2});
        do_reset();
        wait_halt(1'b0, 200, ok);
        checks++;
        if (!ok || obs_fetch.size() != exp_fetch.size() || obs_exec.size() != exp_exec.size()) begin
            failures++;
            $display("FAIL br%0d_counts halted=%b fetches=%0d execs=%0d required 1/%0d/%0d", taken,
                     halted, obs_fetch.size(), obs_exec.size(), exp_fetch.size(), exp_exec.size());
        end
        foreach (exp_fetch[i]) begin
            checks++;
            if (i >= obs_fetch.size() || obs_fetch[i] !== exp_fetch[i]) begin
                failures++;
                $display("FAIL br%0d_fetch%0d got=%h required=%h", taken, i,
                         (i < obs_fetch.size()) ? obs_fetch[i] : 16'hxxxx, exp_fetch[i]);
            end
        end
        foreach (exp_exec[i]) begin
            checks++;
            if (i >= obs_exec.size() || obs_exec[i] !== exp_exec[i]) begin
                failures++;
                $display("FAIL br%0d_exec%0d got=%h required=%h", taken, i,
                         (i < obs_exec.size()) ? obs_exec[i] : '0, exp_exec[i]);
            end
        end
        status = '0;
    endtask

    task automatic test_wrap();
        bit ok;
        new_prog();
        mem[16'hFFFF] = 16'h8000; mem[16'h0000] = 16'h0040; mem[16'h0040] = 16'hF000;
        exp_fetch.push_back(16'hFFFF); exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0040);
        do_reset();
        wait_halt(1'b1, 200, ok);
        checks++;
        if (!ok || obs_w.size() != exp_fetch.size()) begin
            failures++;
            $display("FAIL wrap_counts halted=%b fetches=%0d required 1/%0d", w_halted, obs_w.size(), exp_fetch.size());
        end
        foreach (exp_fetch[i]) begin
            checks++;
            if (i >= obs_w.size() || obs_w[i] !== exp_fetch[i]) begin
                failures++;
                $display("FAIL wrap_fetch%0d got=%h required=%h", i,
                         (i < obs_w.size()) ? obs_w[i] : 16'hxxxx, exp_fetch[i]);
            end
        end
    endtask

    task automatic test_delay();
        bit ok;
        bit acked;
        int unsigned cnt;
        new_prog();
        mem[0] = 16'h1022; mem[1] = 16'hF000;
        exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001);
        exp_exec.push_back('{op:7'h41, rb:1'b0, par:4'h2, imm:16'h0000, rd:3'd0, rs1:3'd0, rs2:3'd4});
        ack_delay = 3;
        do_reset();
        cnt = 0; acked = 1'b0;
        for (int i = 0; i < 20 && !acked; i++) begin
            @(negedge CLK);
            cnt++;
            checks++;
            if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
                failures++;
                $display("FAIL delay_hold cycle%0d req=%b addr=%h required 1/0000", i, mem_req, mem_addr);
            end
            acked = mem_ack;
        end
        checks++;
        if (cnt != 4) begin failures++; $display("FAIL delay_req_cycles got=%0d required=4", cnt); end
        wait_halt(1'b0, 200, ok);
        ack_delay = 0;
        checks++;
        if (!ok || obs_fetch.size() != exp_fetch.size() || obs_exec.size() != 1 || obs_exec[0] !== exp_exec[0]) begin
            failures++;
            $display("FAIL delay_program halted=%b fetches=%0d execs=%0d required 1/2/1", halted, obs_fetch.size(), obs_exec.size());
        end
    endtask

    task automatic test_reset_midwait();
        bit ok;
        new_prog();
        mem[0] = 16'h1022; mem[1] = 16'hF000;
        exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001);
        ack_delay = 100;
        do_reset();
        @(negedge CLK); @(negedge CLK);
        @(posedge CLK); #1 RST = 1'b1; ack_force = 1'b1;
        @(negedge CLK);
        checks++;
        if ({mem_req, mem_addr, operation} !== '0) begin
            failures++;
            $display("FAIL midwait_reset_outputs req=%b addr=%h op=%h required 0", mem_req, mem_addr, operation);
        end
        @(posedge CLK); #1 RST = 1'b0; ack_force = 1'b0; ack_delay = 0;
        wait_halt(1'b0, 200, ok);
        checks++;
        if (!ok || obs_fetch.size() != exp_fetch.size()) begin
            failures++;
            $display("FAIL midwait_counts halted=%b fetches=%0d required 1/%0d", halted, obs_fetch.size(), exp_fetch.size());
        end
        foreach (exp_fetch[i]) begin
            checks++;
            if (i >= obs_fetch.size() || obs_fetch[i] !== exp_fetch[i]) begin
                failures++;
                $display("FAIL midwait_fetch%0d got=%h required=%h", i,
                         (i < obs_fetch.size()) ? obs_fetch[i] : 16'hxxxx, exp_fetch[i]);
            end
        end
    endtask

    task automatic test_illegal();
        bit ok;
        new_prog();
        mem[0] = 16'hA000; mem[1] = 16'hF000;
        exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001);
        do_reset();
        wait_halt(1'b0, 200, ok);
        checks++;
        if (!ok || ill_cnt != 1) begin
            failures++;
            $display("FAIL illegal_pulse halted=%b pulses=%0d required 1/1", halted, ill_cnt);
        end
        checks++;
        if (obs_exec.size() != 0) begin
            failures++;
            $display("FAIL illegal_no_exec strobes=%0d required=0", obs_exec.size());
        end
        foreach (exp_fetch[i]) begin
            checks++;
            if (i >= obs_fetch.size() || obs_fetch[i] !== exp_fetch[i]) begin
                failures++;
                $display("FAIL illegal_fetch%0d got=%h required=%h", i,
                         (i < obs_fetch.size()) ? obs_fetch[i] : 16'hxxxx, exp_fetch[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ldi();
        test_branch(1'b1);
        test_branch(1'b0);
        test_wrap();
        test_delay();
        test_reset_midwait();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control stage directly upstream of the ALU register-file block.
- Fetches 16-bit instruction words from program memory over a req/ack handshake and decodes them into the ALU's control fields (operand/result indices, operation, params, readBus). Drives immediates onto the ALU data input.
- Evaluates conditional branches against the ALU status flags.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- ADDR_W, 16, program address width; PC wraps modulo 2^ADDR_W.

Ports:
- CLK  in  1  system clock, all state on posedge.
- RST  in  1  synchronous, active-high reset.
- mem_req  out  1  fetch request; addr stable while high.
- mem_addr  out  ADDR_W  fetch address (current PC).
- mem_ack  in  1  fetch complete; mem_rdata valid in the same cycle.
- mem_rdata  in  16  fetched word.
- status  in  6  ALU flags: [0] zero, [3] eq, [4] gt, [5] lt.
- operandIndex1  out  3  ALU operand 1 select.
- operandIndex2  out  3  ALU operand 2 select.
- resultsIndex  out  3  ALU destination select.
- operation  out  7  bit 6 = execute strobe, bits 5:0 = one-hot op.
- params  out  4  {2'b00, sub}.
- readBus  out  1  ALU takes operand 2 / load data from imm.
- imm  out  16  immediate word, wired to the ALU din.
- halted  out  1  high in HALT state.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Instruction word format: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2] I (immediate follows), [1:0] sub.
- Opcodes:
  - 0 NOP
  - 1 ADDSUB (op bit0; sub[0]=1 subtract)
  - 2 MUL (bit1)
  - 3 LOG (bit2; sub 0 AND, 1 OR, 2 XOR, 3 NOT)
  - 4 LSH (bit3)
  - 5 RSH (bit4)
  - 6 CMP (bit5)
  - 7 LDI: readBus only, operation=7'b1000000; always fetches an immediate regardless of I.
  - 8 JMP: target in next word.
  - 9 BR: target in next word; branch if selected flag is 1. sub 0 → status[0], 1 → [3], 2 → [4], 3 → [5].
  - 15 HALT
  - 10-14 illegal.
- FSM states: FETCH, DECODE, IMM, EXEC, HALT.
  - FETCH: mem_req=1, mem_addr=pc. On mem_ack, latch ir=mem_rdata, pc<=pc+1, go DECODE.
  - DECODE: go HALT on opcode 15. Go IMM if I=1 or opcode is 7/8/9. Otherwise go EXEC.
  - IMM: mem_req=1, addr=pc. On mem_ack, latch imm, pc<=pc+1, go EXEC.
  - EXEC: exactly one cycle. ALU ops and LDI drive operation[6]=1 plus the one-hot bit. readBus = I, or 1 for LDI. JMP sets pc<=imm. BR sets pc<=imm if taken. Next state FETCH.
  - HALT: terminal until RST.
- Control outputs are combinational from ir/state. They are 0 in every state other than EXEC, except index fields, which may follow ir. The ALU therefore sees operation[6] for exactly one cycle per instruction.
- Branch samples status during EXEC. Status is already updated from any previous EXEC, because at least 2 fetch cycles separate consecutive EXECs.
- Illegal opcode: illegal pulses in DECODE, treated as NOP (EXEC with operation=0).
- Handshake:
  - mem_req stays high and mem_addr holds until ack; there is no timeout.
  - mem_ack while mem_req=0 is ignored.
  - Zero-wait ack means the same cycle as req rises.
- PC increments wrap 16'hFFFF→16'h0000. An IMM fetch at the wrapped address is legal.
- Reset:
  - state=FETCH, pc=RESET_PC, ir=0, imm=0.
  - All outputs 0 during the reset cycle, including mem_req.
  - Reset mid-fetch abandons the request; an ack in the reset cycle is ignored.
  - First mem_req is in the cycle after RST falls.
- Minimum latency: 3 cycles per non-immediate instruction, 4 with an immediate (zero-wait memory).

Optional Feature:
- Macro ALU_SEQ_STEP_EN.
- Enabled:
  - Adds input step (1 bit) and state WAITSTEP, entered after every EXEC and after reset.
  - Leaves WAITSTEP for FETCH in the cycle after step is sampled high.
  - step held high executes one instruction per pass.
- Disabled: no step port; EXEC goes straight to FETCH.

Test Plan:
- Reset, zero-wait memory with words 0x1022 (ADD rd=0, rs1=0, rs2=4) then 0xF000 → mem_addr 0,1. operation=7'h41, operandIndex2=4, resultsIndex=0 for one cycle. halted=1 after the second word.
- LDI: 0x7400 then 0x1234 → readBus=1, imm=16'h1234, operation=7'h40, resultsIndex=2 in EXEC; pc=2 after.
- CMP then BR eq:
  - Taken case: status[3]=1 in EXEC, target 0x0040 → next mem_addr=0x0040.
  - Not-taken case: status[3]=0 → next mem_addr continues at pc+1.
- RESET_PC=16'hFFFF, JMP at 0xFFFF with target at 0x0000 → fetches 0xFFFF, then 0x0000 (imm); next fetch address = target.
- Ack delayed 3 cycles → mem_req/mem_addr stable for all 4 cycles. RST asserted mid-wait with ack in the same cycle → ack ignored; refetch from RESET_PC.
- Opcode 0xA000 → illegal pulses 1 cycle, operation stays 0, next fetch at pc+1.
